// File: rtl/sr_timer_scheduler.sv
// sr_timer_scheduler
//   Round-robin front end that shares one sr_timer_variable pulse timer among
//   N lamp channels. The winner's duration is loaded into T_TIME, the timer is
//   fired with T_S, and its T_OUT is routed back to the owner as LIGHT. ACK
//   marks completion. ERR marks a timer that did not start.
// Ports
//   CLK, RST      clock (rising edge), async active-high reset
//   REQ[N]        level requests, held until ACK; owner drop = abort
//   DUR[N*WIDTH]  per-channel duration, sampled at grant
//   GNT[N]        registered one-hot owner
//   ACK[N]        one-cycle completion pulse
//   LIGHT[N]      GNT gated by T_OUT (combinational)
//   ERR           one-cycle pulse, timer failed to start
//   T_S, T_R      timer start / sync clear pulses
//   T_TIME        timer duration, stable for the whole grant
//   T_OUT         timer output
module sr_timer_scheduler #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic [N*WIDTH-1:0]   DUR,
  output logic [N-1:0]         GNT,
  output logic [N-1:0]         ACK,
  output logic [N-1:0]         LIGHT,
  output logic                 ERR,
  output logic                 T_S,
  output logic                 T_R,
  output logic [WIDTH-1:0]     T_TIME,
  input  logic                 T_OUT
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ARM, BUSY, DONE} state_t;

  state_t           state, nxt;
  logic [PW-1:0]    ptr, idx, pick, idx_inc;
  logic [PW-1:0]    ptr_d, idx_d;
  logic [N-1:0]     gnt_d, ack_d;
  logic             err_d, ts_d, tr_d;
  logic [WIDTH-1:0] time_d, dur_pick;
  logic             own_req;

  // Winner is the set bit at the smallest rotation distance from ptr.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [PW-1:0] p);
    logic [PW-1:0] s;
    int            j;
    s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(p) + k) % N;
      if (r[j]) s = PW'(j);
    end
    return s;
  endfunction

  assign pick     = rr_pick(REQ, ptr);
  assign dur_pick = DUR[int'(pick)*WIDTH +: WIDTH];
  assign idx_inc  = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
  assign own_req  = REQ[idx];
  assign LIGHT    = GNT & {N{T_OUT}};

  // Next state. An owner dropping REQ wins over every other condition
  // while the grant is live; DONE ignores REQ because completion is final.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (!T_OUT && |REQ) nxt = LOAD;
      LOAD: if (!own_req) nxt = IDLE;
            else if (T_TIME == '0) nxt = DONE;
            else nxt = ARM;
      ARM:  if (!own_req || !T_OUT) nxt = IDLE;
            else nxt = BUSY;
      BUSY: if (!own_req) nxt = IDLE;
            else if (!T_OUT) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, all decided on the transition
  // so each pulse lands in the cycle of the state it belongs to.
  always_comb begin
    gnt_d  = GNT;
    ack_d  = '0;
    err_d  = 1'b0;
    ts_d   = 1'b0;
    tr_d   = 1'b0;
    time_d = T_TIME;
    ptr_d  = ptr;
    idx_d  = idx;
    case (state)
      IDLE: begin
        if (T_OUT) tr_d = 1'b1;            // stray timer run: clear it first
        else if (|REQ) begin
          idx_d  = pick;
          gnt_d  = N'(1) << pick;
          time_d = dur_pick;
          ts_d   = (dur_pick != '0);       // zero duration never fires the timer
        end
      end
      LOAD, ARM, BUSY: begin
        if (!own_req || (state == ARM && !T_OUT)) begin
          err_d = own_req;                 // timer failed, not an abort
          tr_d  = 1'b1;
          gnt_d = '0;
          ptr_d = idx_inc;
        end else if ((state == LOAD && T_TIME == '0) ||
                     (state == BUSY && !T_OUT)) begin
          ack_d = GNT;
        end
      end
      DONE: begin
        gnt_d = '0;
        ptr_d = idx_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      ptr    <= '0;
      idx    <= '0;
      GNT    <= '0;
      ACK    <= '0;
      ERR    <= 1'b0;
      T_S    <= 1'b0;
      T_R    <= 1'b1;                      // keeps the timer cleared through reset
      T_TIME <= '0;
    end else begin
      state  <= nxt;
      ptr    <= ptr_d;
      idx    <= idx_d;
      GNT    <= gnt_d;
      ACK    <= ack_d;
      ERR    <= err_d;
      T_S    <= ts_d;
      T_R    <= tr_d;
      T_TIME <= time_d;
    end
  end

endmodule

// File: tb/tb_sr_timer_scheduler.sv
module tb_sr_timer_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [N-1:0]   REQ = '0;
  logic [N*W-1:0] DUR = '0;
  logic [N-1:0]   GNT, ACK, LIGHT;
  logic           ERR, T_S, T_R, T_OUT;
  logic [W-1:0]   T_TIME;

  logic [W-1:0]   cnt;
  bit             fault = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int ptr_m = 0;
  int dur_m [N];

  sr_timer_scheduler #(.N(N), .WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DUR(DUR), .GNT(GNT), .ACK(ACK),
    .LIGHT(LIGHT), .ERR(ERR), .T_S(T_S), .T_R(T_R), .T_TIME(T_TIME),
    .T_OUT(T_OUT)
  );

  always #5 CLK = ~CLK;

  // Timer model: high for T_TIME cycles after T_S; a fault makes it ignore T_S.
  always @(posedge CLK or posedge RST) begin
    if (RST)                 cnt <= '0;
    else if (T_R)            cnt <= '0;
    else if (T_S && !fault)  cnt <= T_TIME;
    else if (cnt != '0)      cnt <= cnt - 1'b1;
  end
  assign T_OUT = (cnt != '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Round robin as a forward rotation search from the pointer.
  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_dur();
    for (int i = 0; i < N; i++) DUR[i*W +: W] = W'(dur_m[i]);
  endtask

  // One grant from the IDLE cycle that precedes it. mode 0 normal,
  // 1 abort at BUSY offset jab, 2 timer fault. Returns at an IDLE negedge.
  task automatic grant(input int mode, input int jab, input bit keep, output int idx);
    int d;
    logic [N-1:0] oh;
    idx = rr(REQ, ptr_m);
    if (idx < 0) begin
      chk("no_req", 32'(REQ), 32'hFFFF_FFFF);
      return;
    end
    d  = dur_m[idx];
    oh = N'(1) << idx;
    @(negedge CLK);                                  // LOAD
    chk("gnt", 32'(GNT), 32'(oh));
    chk("ts", 32'(T_S), 32'(d != 0));
    chk("ttime", 32'(T_TIME), 32'(d));
    chk("light_load", 32'(LIGHT), 0);
    if (d == 0) begin
      @(negedge CLK);
      chk("ack_d0", 32'(ACK), 32'(oh));
      chk("light_d0", 32'(LIGHT), 0);
      chk("gnt_d0", 32'(GNT), 32'(oh));
      if (!keep) REQ[idx] = 1'b0;
      @(negedge CLK);
      chk("gnt_off_d0", 32'(GNT), 0);
      chk("ack_off_d0", 32'(ACK), 0);
    end else if (mode == 2) begin
      fault = 1'b1;
      @(negedge CLK);                                // ARM, timer dead
      chk("light_flt", 32'(LIGHT), 0);
      @(negedge CLK);
      chk("err", 32'(ERR), 1);
      chk("tr_flt", 32'(T_R), 1);
      chk("gnt_flt", 32'(GNT), 0);
      chk("ack_flt", 32'(ACK), 0);
      fault = 1'b0;
    end else if (mode == 1) begin
      for (int c = 0; c <= jab; c++) begin
        @(negedge CLK);
        chk("light_ab", 32'(LIGHT), 32'(oh));
      end
      REQ[idx] = 1'b0;
      @(negedge CLK);
      chk("gnt_ab", 32'(GNT), 0);
      chk("tr_ab", 32'(T_R), 1);
      chk("ack_ab", 32'(ACK), 0);
      chk("light_ab0", 32'(LIGHT), 0);
      @(negedge CLK);                                // timer still ran one cycle
      chk("tr_stray", 32'(T_R), 1);
      chk("gnt_stray", 32'(GNT), 0);
    end else begin
      for (int c = 0; c < d; c++) begin
        @(negedge CLK);
        chk("light", 32'(LIGHT), 32'(oh));
        chk("ack_early", 32'(ACK), 0);
      end
      @(negedge CLK);
      chk("light_off", 32'(LIGHT), 0);
      chk("gnt_hold", 32'(GNT), 32'(oh));
      @(negedge CLK);
      chk("ack", 32'(ACK), 32'(oh));
      chk("gnt_ack", 32'(GNT), 32'(oh));
      chk("err_ok", 32'(ERR), 0);
      if (!keep) REQ[idx] = 1'b0;
      @(negedge CLK);
      chk("gnt_off", 32'(GNT), 0);
      chk("ack_off", 32'(ACK), 0);
    end
    ptr_m = (idx + 1) % N;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, 32'(GNT), 0);
    chk({tag, "_ack"}, 32'(ACK), 0);
    chk({tag, "_err"}, 32'(ERR), 0);
    chk({tag, "_ts"}, 32'(T_S), 0);
    chk({tag, "_tr"}, 32'(T_R), 1);
    chk({tag, "_ttime"}, 32'(T_TIME), 0);
    chk({tag, "_light"}, 32'(LIGHT), 0);
  endtask

  initial begin
    int idx, d, mode, jab;
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    #1 RST = 1'b1;
    #1 chk_reset_vals("rst");
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    chk("tr_hold", 32'(T_R), 1);
    @(negedge CLK);
    chk("tr_rel", 32'(T_R), 0);

    // all four requesting, served in rotation
    for (int i = 0; i < N; i++) dur_m[i] = 2;
    set_dur();
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      grant(0, 0, 1'b1, idx);
      chk("rr_order", idx, rr_exp[i]);
    end
    REQ = '0;

    // single channel
    dur_m[1] = 5; set_dur();
    REQ = 4'b0010;
    grant(0, 0, 1'b0, idx);
    chk("single_idx", idx, 1);

    // abort two cycles into BUSY, pointer moves past the aborter
    dur_m[2] = 6; set_dur();
    REQ = 4'b0100;
    grant(1, 2, 1'b0, idx);
    REQ = 4'b1111;
    grant(0, 0, 1'b0, idx);
    chk("abort_ptr", idx, 3);
    REQ = '0;

    // zero duration
    dur_m[3] = 0; set_dur();
    REQ = 4'b1000;
    grant(0, 0, 1'b0, idx);

    // maximum duration
    dur_m[0] = 255; set_dur();
    REQ = 4'b0001;
    grant(0, 0, 1'b0, idx);

    // timer fault
    dur_m[0] = 4; set_dur();
    REQ = 4'b0001;
    grant(2, 0, 1'b0, idx);
    REQ = '0;

    // random traffic
    repeat (150) begin
      if (REQ == '0 || $urandom_range(0, 3) == 0) begin
        REQ = REQ | N'($urandom);
        if (REQ == '0) REQ[$urandom_range(0, N-1)] = 1'b1;
        for (int i = 0; i < N; i++) dur_m[i] = $urandom_range(0, 7);
        set_dur();
      end
      d    = dur_m[rr(REQ, ptr_m)];
      mode = 0;
      jab  = 0;
      if (d >= 3 && $urandom_range(0, 4) == 0) begin
        mode = 1;
        jab  = $urandom_range(1, d - 2);
      end else if (d >= 1 && $urandom_range(0, 6) == 0) mode = 2;
      grant(mode, jab, 1'($urandom_range(0, 2) == 0), idx);
    end

    // reset in the middle of BUSY
    REQ = '0;
    @(negedge CLK);
    dur_m[1] = 6; set_dur();
    REQ = 4'b0010;
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    chk("busy_light", 32'(LIGHT), 32'(4'b0010));
    #2 RST = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge CLK);
    REQ = '0;
    RST = 1'b0;
    ptr_m = 0;
    @(negedge CLK);
    chk("post_rst_tr", 32'(T_R), 0);
    chk("post_rst_out", 32'(T_OUT), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
